// File: rtl/embcpu4k_onchip_mem_arbiter_if.sv
// embcpu4k_onchip_mem_arbiter_if: Avalon-MM bundle for one master port of the RAM arbiter
interface embcpu4k_onchip_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/embcpu4k_onchip_mem_arbiter.sv
// embcpu4k_onchip_mem_arbiter: round-robin, burst-limited sharing of one single-port RAM by two Avalon-MM masters
module embcpu4k_onchip_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    embcpu4k_onchip_mem_arbiter_if.slave m0,
    embcpu4k_onchip_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic       req0, req1, grant0, grant1, keep;
    logic       last_owner_q, last_owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rv0_q, rv0_d, rv1_q, rv1_d;

    // Grant decision; a zero burst count means no burst is running, so a tie goes away from last_owner
    always_comb begin
        req0   = m0.read | m0.write;
        req1   = m1.read | m1.write;
        keep   = (burst_cnt_q != 4'd0) && (burst_cnt_q < MAX_B);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                grant1 = keep ? last_owner_q : ~last_owner_q;
                grant0 = ~grant1;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    // Next owner/burst state and read-valid pipeline; a read+write access counts as a write only
    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        if (grant0 | grant1) begin
            if (grant1 == last_owner_q) begin
                burst_cnt_d = (burst_cnt_q < MAX_B) ? burst_cnt_q + 4'd1 : MAX_B;
            end else begin
                last_owner_d = grant1;
                burst_cnt_d  = 4'd1;
            end
        end
        rv0_d = grant0 & m0.read & ~m0.write;
        rv1_d = grant1 & m1.read & ~m1.write;
    end

    // RAM-side mux and master-side responses; everything is held quiet while in reset
    always_comb begin
        mem_address      = grant1 ? m1.address    : m0.address;
        mem_byteenable   = grant1 ? m1.byteenable : m0.byteenable;
        mem_writedata    = grant1 ? m1.writedata  : m0.writedata;
        mem_chipselect   = grant0 | grant1;
        mem_write        = (grant0 & m0.write) | (grant1 & m1.write);
        mem_clken        = reset_n;
        m0.waitrequest   = ~reset_n | (req0 & ~grant0);
        m1.waitrequest   = ~reset_n | (req1 & ~grant1);
        m0.readdata      = mem_readdata;
        m1.readdata      = mem_readdata;
        m0.readdatavalid = rv0_q;
        m1.readdatavalid = rv1_q;
    end

    // State registers; async reset drops any read still in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rv0_q        <= rv0_d;
            rv1_q        <= rv1_d;
        end
    end
endmodule

// File: tb/tb_embcpu4k_onchip_mem_arbiter.sv
// tb_embcpu4k_onchip_mem_arbiter: randomized and directed checks of the RAM arbiter against a grant-history model
module tb_embcpu4k_onchip_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    embcpu4k_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    embcpu4k_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, mem_readdata;

    embcpu4k_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Single-port synchronous RAM, 1-cycle read latency
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] ram_q;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: list of past grants, a byte-tracked copy of memory, pending read results
    int            hist[$];
    logic [DW-1:0] refmem [1024];
    logic [3:0]    kb [1024];
    bit            exp_rv [2];
    logic [DW-1:0] exp_d [2];
    bit            exp_known [2];
    bit            waited [2];
    int            obs_g;
    bit            obs_rv0;
    logic [DW-1:0] obs_rd0;
    int            rv_cnt [2];
    int            wait_cnt [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int streak();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1] || n >= MB) break;
            n++;
        end
        return n;
    endfunction

    function automatic int predict(input bit r0, input bit r1);
        if (r0 && r1) begin
            if (hist.size() == 0) return 0;
            return (streak() < MB) ? hist[hist.size()-1] : 1 - hist[hist.size()-1];
        end
        return r0 ? 0 : (r1 ? 1 : -1);
    endfunction

    task automatic drive(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 4'h0, '0);
        drive(1, 0, 0, '0, 4'h0, '0);
    endtask

    task automatic tick();
        bit r0, r1, rd, wr;
        int g;
        logic [AW-1:0] a;
        logic [3:0] be;
        logic [DW-1:0] wd;
        @(negedge clk);
        r0 = m0_if.read | m0_if.write;
        r1 = m1_if.read | m1_if.write;
        g = predict(r0, r1);
        chk("wait0", m0_if.waitrequest, r0 && g != 0);
        chk("wait1", m1_if.waitrequest, r1 && g != 1);
        chk("chipselect", mem_chipselect, g >= 0);
        chk("clken", mem_clken, 1);
        chk("rv0", m0_if.readdatavalid, exp_rv[0]);
        chk("rv1", m1_if.readdatavalid, exp_rv[1]);
        if (exp_rv[0] && exp_known[0]) chk("rdata0", m0_if.readdata, exp_d[0]);
        if (exp_rv[1] && exp_known[1]) chk("rdata1", m1_if.readdata, exp_d[1]);
        if (m0_if.readdatavalid) rv_cnt[0]++;
        if (m1_if.readdatavalid) rv_cnt[1]++;
        if (r0 && m0_if.waitrequest) wait_cnt[0]++;
        if (r1 && m1_if.waitrequest) wait_cnt[1]++;
        waited[0] = r0 && m0_if.waitrequest;
        waited[1] = r1 && m1_if.waitrequest;
        obs_rv0 = m0_if.readdatavalid;
        obs_rd0 = m0_if.readdata;
        obs_g = (r0 && !m0_if.waitrequest) ? 0 : (r1 && !m1_if.waitrequest) ? 1 : -1;
        exp_rv[0] = 0;
        exp_rv[1] = 0;
        if (g >= 0) begin
            rd = (g == 1) ? m1_if.read : m0_if.read;
            wr = (g == 1) ? m1_if.write : m0_if.write;
            a  = (g == 1) ? m1_if.address : m0_if.address;
            be = (g == 1) ? m1_if.byteenable : m0_if.byteenable;
            wd = (g == 1) ? m1_if.writedata : m0_if.writedata;
            chk("mem_write", mem_write, wr);
            chk("mem_address", mem_address, a);
            if (wr) begin
                chk("mem_be", mem_byteenable, be);
                chk("mem_wdata", mem_writedata, wd);
                for (int b = 0; b < 4; b++)
                    if (be[b]) refmem[a][b*8 +: 8] = wd[b*8 +: 8];
                kb[a] = kb[a] | be;
            end else if (rd) begin
                exp_rv[g] = 1;
                exp_d[g] = refmem[a];
                exp_known[g] = (kb[a] == 4'hF);
            end
            hist.push_back(g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_wait0", m0_if.waitrequest, 1);
        chk("rst_wait1", m1_if.waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_we", mem_write, 0);
        chk("rst_clken", mem_clken, 0);
        chk("rst_rv0", m0_if.readdatavalid, 0);
        chk("rst_rv1", m1_if.readdatavalid, 0);
        hist.delete();
        exp_rv[0] = 0;
        exp_rv[1] = 0;
        waited[0] = 0;
        waited[1] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rv1_hold", m1_if.readdatavalid, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) kb[i] = 4'h0;
        idle();
        #1;
        drive(0, 1, 0, 10'h001, 4'hF, '0);
        drive(1, 1, 0, 10'h002, 4'hF, '0);
        do_reset();

        // Write then read back at the top address
        idle();
        drive(0, 0, 1, 10'h3FF, 4'hF, 32'hDEADBEEF);
        tick();
        chk("t1_wr_grant", obs_g, 0);
        drive(0, 1, 0, 10'h3FF, 4'hF, '0);
        tick();
        chk("t1_rd_grant", obs_g, 0);
        idle();
        tick();
        chk("t1_rv", obs_rv0, 1);
        chk("t1_data", obs_rd0, 32'hDEADBEEF);

        // Continuous tie: four grants each, alternating, from reset
        do_reset();
        drive(0, 1, 0, 10'h005, 4'hF, '0);
        drive(1, 1, 0, 10'h006, 4'hF, '0);
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t2_grant", obs_g, (i / 4) % 2);
        end
        chk("t2_wait0", wait_cnt[0], 8);
        chk("t2_wait1", wait_cnt[1], 8);

        // Partial byte write from m1 merges into the existing word
        idle();
        drive(0, 0, 1, 10'h010, 4'hF, 32'h11223344);
        tick();
        idle();
        drive(1, 0, 1, 10'h010, 4'b0010, 32'h0000AB00);
        tick();
        idle();
        drive(0, 1, 0, 10'h010, 4'hF, '0);
        tick();
        idle();
        tick();
        chk("t3_data", obs_rd0, 32'h1122AB44);

        // m0 streams alone, then m1 joins and must be served quickly
        do_reset();
        idle();
        rv_cnt[0] = 0;
        wait_cnt[0] = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, AW'(i), 4'hF, '0);
            tick();
        end
        idle();
        tick();
        chk("t4_rv_count", rv_cnt[0], 10);
        chk("t4_no_wait", wait_cnt[0], 0);
        begin
            int n = 0;
            drive(0, 1, 0, 10'h020, 4'hF, '0);
            drive(1, 1, 0, 10'h021, 4'hF, '0);
            for (int i = 0; i < 4; i++) begin
                tick();
                drive(0, 1, 0, 10'h022, 4'hF, '0);
                if (obs_g == 1) break;
                n++;
            end
            tick();
            chk("t4_m1_served", n <= 4 && obs_g != -1, 1);
        end

        // Reset with an m1 read in flight drops its valid; first tie after goes to m0
        idle();
        drive(1, 1, 0, 10'h3FF, 4'hF, '0);
        tick();
        chk("t5_rv1_pending", m1_if.readdatavalid, 1);
        do_reset();
        drive(0, 1, 0, 10'h030, 4'hF, '0);
        drive(1, 1, 0, 10'h031, 4'hF, '0);
        tick();
        chk("t5_first_tie", obs_g, 0);

        // Read and write together: write happens, no read valid
        idle();
        drive(0, 1, 1, 10'h040, 4'hF, 32'hCAFEF00D);
        tick();
        idle();
        tick();
        chk("t6_no_rv", obs_rv0, 0);
        drive(0, 1, 0, 10'h040, 4'hF, '0);
        tick();
        idle();
        tick();
        chk("t6_data", obs_rd0, 32'hCAFEF00D);

        // Randomized traffic on a small address window to provoke hazards and contention
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                do_reset();
            end
            for (int m = 0; m < 2; m++) begin
                if (!waited[m]) begin
                    int op = $urandom_range(0, 9);
                    drive(m, op inside {[3:6]} || op == 9, op inside {[7:9]},
                          AW'($urandom_range(0, 15)), 4'($urandom), $urandom);
                end
            end
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
